// File: rtl/opamp_sd_dac_driver.sv
// rtl/opamp_sd_dac_driver.sv - first-order sigma-delta DAC driver feeding the op-amp pad
// Optional dither LFSR on the carry-in is enabled with `define OPAMP_SD_DITHER_EN.
module opamp_sd_dac_driver #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [DIV_W-1:0] div,
    input  logic             ramp_en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic [WIDTH-1:0] level,
    output logic             busy,
    output logic             dac_out
);

    typedef enum logic [1:0] {IDLE, RUN, RAMP} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] level_step;
    logic [WIDTH:0]   sum;
    logic             active;
    logic             tick;
    logic             xfer;
    logic             cin;

    assign active     = ena && (state != IDLE);
    assign tick       = active && (cnt == div);
    assign load_ready = (state == RUN) && ena;
    assign busy       = (state == RAMP);
    assign xfer       = load_valid && load_ready;
    assign sum        = {1'b0, acc} + {1'b0, level} + {{WIDTH{1'b0}}, cin};
    assign level_step = (target > level) ? level + 1'b1 : level - 1'b1;

`ifdef OPAMP_SD_DITHER_EN
    logic [8:0] lfsr;

    // x^9 + x^5 + 1; only steps on ticks, so it freezes in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 9'h1FF;
        end else if (tick) begin
            lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        end
    end

    assign cin = lfsr[0];
`else
    assign cin = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ena) state_nxt = RUN;
            RUN: begin
                if (!ena)
                    state_nxt = IDLE;
                else if (xfer && ramp_en && (load_data != level))
                    state_nxt = RAMP;
            end
            RAMP: begin
                if (!ena)
                    state_nxt = IDLE;
                else if (tick && (level_step == target))
                    state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            level   <= '0;
            target  <= '0;
            dac_out <= 1'b0;
        end else begin
            state <= state_nxt;

            // count > div after a div change wraps without producing a tick
            if (!active || (cnt >= div))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (!active) begin
                acc     <= '0;
                dac_out <= 1'b0;
            end else if (tick) begin
                {dac_out, acc} <= sum;
            end

            // accumulation above sees the pre-update level on the same edge
            if ((state == RUN) && xfer && !ramp_en)
                level <= load_data;
            else if ((state == RAMP) && tick)
                level <= level_step;

            if ((state == RUN) && xfer && ramp_en)
                target <= load_data;
        end
    end

endmodule

// File: tb/tb_opamp_sd_dac_driver.sv
// tb/tb_opamp_sd_dac_driver.sv - directed self-checking bench for opamp_sd_dac_driver
module tb_opamp_sd_dac_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] div = 8'd0;
    logic       ramp_en = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'd0;
    logic       load_ready;
    logic [7:0] level;
    logic       busy;
    logic       dac_out;

    int checks = 0;
    int failures = 0;

    opamp_sd_dac_driver #(.WIDTH(8), .DIV_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .div        (div),
        .ramp_en    (ramp_en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .level      (level),
        .busy       (busy),
        .dac_out    (dac_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ena = 1'b1; div = 8'd0; ramp_en = 1'b0; load_valid = 1'b0; load_data = 8'd0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic load(input logic [7:0] d, input logic r);
        ramp_en = r; load_data = d; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1;
        step();
        step();
        checks++; if (dac_out !== 1'b0) begin failures++; $display("FAIL reset_dac_out got=%b exp=0", dac_out); end
        checks++; if (level !== 8'h00) begin failures++; $display("FAIL reset_level got=%h exp=00", level); end
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL reset_load_ready got=%b exp=0", load_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_early got=%b exp=0", load_ready); end
        step();
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_rise got=%b exp=1", load_ready); end
    endtask

    task automatic test_duty();
        int ones = 0;
        int last = -1;
        int bad_gap = 0;
        do_reset();
        load(8'h40, 1'b0);
        for (int i = 0; i < 256; i++) begin
            step();
            if (dac_out) begin
                ones++;
                if (last >= 0 && (i - last) != 4) bad_gap++;
                last = i;
            end
        end
        checks++; if (ones !== 64) begin failures++; $display("FAIL duty_40_ones got=%0d exp=64", ones); end
        checks++; if (bad_gap !== 0) begin failures++; $display("FAIL duty_40_spacing bad_gaps=%0d exp=0", bad_gap); end
        load(8'h00, 1'b0);
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (dac_out) ones++;
        end
        checks++; if (ones !== 0) begin failures++; $display("FAIL duty_00_ones got=%0d exp=0", ones); end
    endtask

    task automatic test_full_scale();
        int zeros = 0;
        do_reset();
        load(8'hFF, 1'b0);
        for (int i = 0; i < 256; i++) begin
            step();
            if (!dac_out) zeros++;
        end
        checks++; if (zeros !== 1) begin failures++; $display("FAIL duty_ff_zeros got=%0d exp=1", zeros); end
    endtask

    task automatic test_prescaler();
        int changes = 0;
        int last = -1;
        int bad_gap = 0;
        int found = 0;
        logic prev;
        logic exp_chg [7];
        exp_chg = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        div = 8'd3;
        load(8'h80, 1'b0);
        prev = dac_out;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dac_out !== prev) begin
                changes++;
                if (last >= 0 && (i - last) != 4) bad_gap++;
                last = i;
            end
            prev = dac_out;
        end
        checks++; if (changes !== 9) begin failures++; $display("FAIL presc_changes got=%0d exp=9", changes); end
        checks++; if (bad_gap !== 0) begin failures++; $display("FAIL presc_spacing bad_gaps=%0d exp=0", bad_gap); end
        for (int i = 0; i < 8 && found == 0; i++) begin
            step();
            if (dac_out !== prev) found = 1;
            prev = dac_out;
        end
        checks++; if (found !== 1) begin failures++; $display("FAIL presc_sync_timeout got=%0d exp=1", found); end
        step(); step(); step();
        prev = dac_out;
        div = 8'd1;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if ((dac_out !== prev) !== exp_chg[i]) begin
                failures++;
                $display("FAIL presc_div_change step=%0d toggled=%b exp=%b", i, dac_out !== prev, exp_chg[i]);
            end
            prev = dac_out;
        end
    endtask

    task automatic test_ramp();
        logic [7:0] exp_lvl [4];
        exp_lvl = '{8'h11, 8'h12, 8'h13, 8'h14};
        do_reset();
        load(8'h10, 1'b0);
        checks++; if (level !== 8'h10) begin failures++; $display("FAIL ramp_preload got=%h exp=10", level); end
        ramp_en = 1'b1; load_data = 8'h14; load_valid = 1'b1;
        step();
        load_data = 8'h30;
        checks++; if (busy !== 1'b1 || load_ready !== 1'b0) begin failures++; $display("FAIL ramp_enter busy=%b ready=%b exp=1/0", busy, load_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 2) load_valid = 1'b0;
            checks++;
            if (level !== exp_lvl[i] || busy !== (i < 3) || load_ready !== (i == 3)) begin
                failures++;
                $display("FAIL ramp_step%0d level=%h busy=%b ready=%b exp=%h/%b/%b", i, level, busy, load_ready, exp_lvl[i], i < 3, i == 3);
            end
        end
        step(); step();
        checks++; if (level !== 8'h14 || busy !== 1'b0) begin failures++; $display("FAIL ramp_ignore level=%h busy=%b exp=14/0", level, busy); end
    endtask

    task automatic test_ramp_full();
        int n = 0;
        do_reset();
        load(8'hFF, 1'b1);
        while (busy && n < 400) begin
            step();
            n++;
        end
        checks++; if (n !== 255) begin failures++; $display("FAIL ramp_full_ticks got=%0d exp=255", n); end
        checks++; if (level !== 8'hFF) begin failures++; $display("FAIL ramp_full_level got=%h exp=ff", level); end
    endtask

    task automatic test_abort();
        do_reset();
        load(8'h10, 1'b0);
        load(8'h20, 1'b1);
        step(); step(); step();
        checks++; if (level !== 8'h13 || busy !== 1'b1) begin failures++; $display("FAIL abort_pre level=%h busy=%b exp=13/1", level, busy); end
        ena = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || load_ready !== 1'b0 || dac_out !== 1'b0 || level !== 8'h13) begin
            failures++;
            $display("FAIL abort_idle busy=%b ready=%b dac=%b level=%h exp=0/0/0/13", busy, load_ready, dac_out, level);
        end
        step(); step(); step();
        checks++; if (level !== 8'h13 || dac_out !== 1'b0) begin failures++; $display("FAIL abort_hold level=%h dac=%b exp=13/0", level, dac_out); end
        ena = 1'b1;
        step();
        checks++; if (load_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_resume ready=%b busy=%b exp=1/0", load_ready, busy); end
        for (int i = 0; i < 10; i++) step();
        checks++; if (level !== 8'h13 || busy !== 1'b0) begin failures++; $display("FAIL abort_no_target level=%h busy=%b exp=13/0", level, busy); end
    endtask

    task automatic test_dither();
        int ones = 0;
        do_reset();
        for (int i = 0; i < 512; i++) begin
            step();
            if (dac_out) ones++;
        end
        checks++;
`ifdef OPAMP_SD_DITHER_EN
        if (ones == 0) begin failures++; $display("FAIL dither_ones got=%0d exp>0", ones); end
`else
        if (ones !== 0) begin failures++; $display("FAIL dither_ones got=%0d exp=0", ones); end
`endif
    endtask

    initial begin
        test_reset();
        test_duty();
        test_full_scale();
        test_prescaler();
        test_ramp();
        test_ramp_full();
        test_abort();
        test_dither();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opamp_sd_dac_driver.md
Name: opamp_sd_dac_driver

Overview:
- Digital stage directly upstream of the on-chip op-amp macro.
- Converts a WIDTH-bit code into a first-order sigma-delta bitstream on dac_out.
- dac_out is routed to a pad, RC-filtered externally, and fed to the op-amp non-inverting input.
- Provides a load handshake, a programmable bit-rate prescaler, and an optional soft-start ramp so the op-amp output does not step abruptly.

Parameters:
- WIDTH, 8: code width and accumulator width.
- DIV_W, 8: width of the prescaler divide value.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  block enable; low forces IDLE.
- div  input  DIV_W  tick period minus one; 0 gives one tick per clk.
- ramp_en  input  1  when high, new codes are approached one LSB per tick.
- load_valid  input  1  new code offered.
- load_data  input  WIDTH  code offered.
- load_ready  output  1  block can accept a code this cycle.
- level  output  WIDTH  code currently being modulated.
- busy  output  1  high while in RAMP.
- dac_out  output  1  registered sigma-delta bitstream.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; prescaler=0; acc=0; level=0; target=0; dac_out=0; load_ready=0; busy=0.
- Prescaler:
  - Counts 0..div; tick asserts on the cycle the count equals div, then the count wraps to 0.
  - div changing mid-count: the new value is compared immediately. If count > div, the count wraps to 0 on the next edge without asserting tick.
  - The prescaler is held at 0 in IDLE.
- Modulator, on each tick edge:
  - {carry, acc} <= acc + level + cin, evaluated at WIDTH+1 bits; cin=0 unless dithered.
  - dac_out <= carry.
  - Between ticks, acc and dac_out hold.
- Duty: for a constant level L and no dither, exactly L ones in every 2^WIDTH consecutive ticks.
  - L=0 gives a constant 0.
  - L=2^WIDTH-1 gives one 0 per 2^WIDTH ticks.
- States:
  - IDLE: entered on reset or ena=0, including mid-RAMP, where target is abandoned. Clears acc and dac_out; level holds. Moves to RUN on the first cycle with ena=1.
  - RUN: load_ready=1.
    - On load_valid with ramp_en=0: level <= load_data; stay in RUN.
    - On load_valid with ramp_en=1 and load_data != level: target <= load_data; go to RAMP.
    - On load_valid with ramp_en=1 and load_data == level: stay in RUN.
  - RAMP: load_ready=0; busy=1.
    - On each tick: level increments or decrements by 1 toward target. The accumulator update in that tick uses the pre-step level.
    - When the stepped level equals target, go to RUN on the same edge.
- Handshake:
  - A transfer occurs when load_valid and load_ready are both high at a clk edge.
  - A load takes effect at the following tick.
  - load_data is not sampled when load_ready=0.
- A load accepted on a tick edge in RUN with ramp_en=0 updates level at that edge. That tick's accumulation uses the old level.
- level never wraps: ramping from 0x00 to 0xFF takes exactly 255 ticks.

Optional Feature:
- Macro: OPAMP_SD_DITHER_EN.
- Defined:
  - A 9-bit Fibonacci LFSR (x^9+x^5+1, seed 9'h1FF on reset) advances each tick.
  - Its bit 0 drives cin, which breaks idle tones at low codes.
  - The expected duty bias is +0.5 LSB.
  - In IDLE, the LFSR holds its value.
- Undefined:
  - cin is tied to 0 and no LFSR exists.
  - The exact duty rule applies.

Test Plan:
- Reset check: drive rst=1 for 2 cycles with ena=1 -> dac_out=0, level=0, load_ready=0, busy=0. load_ready rises on the cycle after rst falls.
- Duty check: div=0, ramp_en=0, load 8'h40 -> exactly 64 ones in 256 ticks, with ones spaced every 4 ticks. Then load 8'h00 -> dac_out stays 0.
- Prescaler check: div=3, level=8'h80 -> dac_out changes at most once per 4 clk cycles and toggles on every tick. Changing div to 1 with the count at 3 -> count wraps with no tick.
- Ramp check: ramp_en=1, level=8'h10, load 8'h14 -> busy high for 4 ticks, level reads 11,12,13,14, load_ready=0 throughout. Return to RUN on the 4th tick. A second load_valid during RAMP is ignored.
- Abort check: drop ena mid-RAMP -> IDLE next edge, dac_out=0, level held. Raise ena -> RUN; the old target is not resumed.
- Dither check (OPAMP_SD_DITHER_EN defined): level=0 -> dac_out shows nonzero ones over 512 ticks. With the macro undefined, the same stimulus gives 0 ones.
